// File: rtl/serializer_arbiter.sv
// Round-robin arbiter sharing one NUM_WORDS x WIDTH serializer between NUM_REQ requesters.
// Captures the winner's parallel word, pulses the serializer load strobe, then waits out the burst.
module serializer_arbiter #(
    parameter  int WIDTH     = 8,
    parameter  int NUM_WORDS = 4,
    parameter  int NUM_REQ   = 4,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int P         = NUM_WORDS * WIDTH
) (
    input  logic                   clk,
    input  logic                   i_reset_n,
    input  logic                   i_enable,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ*P-1:0]   i_data,
    output logic [NUM_REQ-1:0]     o_ack,
    output logic [P-1:0]           o_ser_data,
    output logic                   o_ser_dv,
    output logic [IDW-1:0]         o_ser_id,
    output logic                   o_busy
);

    // state | meaning
    // IDLE  | arbitrating; grant captured on the edge leaving IDLE
    // LOAD  | one cycle: o_ser_dv and o_ack[winner] high
    // BUSY  | NUM_WORDS cycles while the serializer shifts the word out
    localparam int CW = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [P-1:0]         data_q, data_d;
    logic                 dv_q, dv_d;
    logic [IDW-1:0]       id_q, id_d;

    logic                 found;
    logic                 grant;
    logic [IDW-1:0]       win;
    logic [IDW-1:0]       scan_idx;
    int                   scan;
    logic [P-1:0]         win_data;

    // Scan ptr, ptr+1, ... wrapping; first set request wins.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan     = 0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = int'(ptr_q) + i;
            if (scan >= NUM_REQ) scan = scan - NUM_REQ;
            scan_idx = IDW'(scan);
            if (!found && i_req[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDW'(k) == win) win_data = i_data[k*P +: P];
        end
    end

    assign grant = (state_q == IDLE) && i_enable && found;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = LOAD;
                    ptr_d   = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                end
            end
            LOAD: begin
                state_d = BUSY;
                cnt_d   = CW'(NUM_WORDS);
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word and id are held from one grant to the next so they stay stable over the burst.
    always_comb begin
        ack_d  = '0;
        dv_d   = 1'b0;
        data_d = data_q;
        id_d   = id_q;
        if (grant) begin
            ack_d[win] = 1'b1;
            dv_d       = 1'b1;
            data_d     = win_data;
            id_d       = win;
        end
    end

    assign o_ack      = ack_q;
    assign o_ser_data = data_q;
    assign o_ser_dv   = dv_q;
    assign o_ser_id   = id_q;
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serializer_arbiter.sv
// Scoreboard bench for serializer_arbiter with a little-endian serializer model on its output.
module tb_serializer_arbiter;

    localparam int W  = 8;
    localparam int NW = 4;
    localparam int NR = 4;
    localparam int P  = NW * W;

    logic            clk = 1'b0;
    logic            i_reset_n;
    logic            i_enable;
    logic [NR-1:0]   i_req;
    logic [NR*P-1:0] i_data;
    logic [NR-1:0]   o_ack;
    logic [P-1:0]    o_ser_data;
    logic            o_ser_dv;
    logic [1:0]      o_ser_id;
    logic            o_busy;

    serializer_arbiter #(.WIDTH(W), .NUM_WORDS(NW), .NUM_REQ(NR)) dut (
        .clk        (clk),
        .i_reset_n  (i_reset_n),
        .i_enable   (i_enable),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_ser_data (o_ser_data),
        .o_ser_dv   (o_ser_dv),
        .o_ser_id   (o_ser_id),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        int          gap;
    } grant_t;

    typedef struct {
        logic [7:0] b;
        logic [1:0] id;
        int         j;
    } word_t;

    grant_t gq[$];
    word_t  bq[$];
    grant_t g;
    word_t  wd;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     last_dv = 0;
    logic [3:0] exp_ack;

    // Serializer model: loads on the edge where i_dv is high, emits LSB word first.
    logic [31:0] sh;
    logic [2:0]  sc;
    logic        ser_v;
    logic [7:0]  ser_byte;
    always @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sh <= '0;
            sc <= '0;
        end else if (o_ser_dv) begin
            sh <= o_ser_data;
            sc <= 3'(NW);
        end else if (sc != 0) begin
            sh <= sh >> 8;
            sc <= sc - 3'd1;
        end
    end
    assign ser_v    = (sc != 0);
    assign ser_byte = sh[7:0];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_grant(input logic [1:0] id, input logic [31:0] data, input int gap);
        grant_t e;
        word_t  w;
        e.id = id; e.data = data; e.gap = gap;
        gq.push_back(e);
        for (int j = 0; j < NW; j++) begin
            w.b  = data[j*8 +: 8];
            w.id = id;
            w.j  = j + 1;
            bq.push_back(w);
        end
    endtask

    task automatic set_slice(input int k, input logic [31:0] v);
        i_data[k*P +: P] = v;
    endtask

    task automatic wait_ack(input int k);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (o_ack[k]) got = 1'b1;
        end
        check($sformatf("wait_ack%0d", k), 64'(got), 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ack"},  64'(o_ack),      64'd0);
        check({tag, "_dv"},   64'(o_ser_dv),   64'd0);
        check({tag, "_data"}, 64'(o_ser_data), 64'd0);
        check({tag, "_id"},   64'(o_ser_id),   64'd0);
        check({tag, "_busy"}, 64'(o_busy),     64'd0);
    endtask

    // Monitor: pops an expected grant on every load pulse, an expected word on every serial beat.
    always @(negedge clk) begin
        if (i_reset_n) begin
            if (o_ser_dv || (o_ack != '0)) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: ack=%b dv=%b id=%0d, expected no grant", o_ack, o_ser_dv, o_ser_id);
                end else begin
                    g = gq.pop_front();
                    exp_ack = 4'b0001 << g.id;
                    check("grant_ack",  64'(o_ack),      64'(exp_ack));
                    check("grant_dv",   64'(o_ser_dv),   64'd1);
                    check("grant_id",   64'(o_ser_id),   64'(g.id));
                    check("grant_data", 64'(o_ser_data), 64'(g.data));
                    if (g.gap > 0) check("dv_spacing", 64'(cyc - last_dv), 64'(g.gap));
                    last_dv = cyc;
                end
            end
            if (ser_v) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h, expected none", ser_byte);
                end else begin
                    wd = bq.pop_front();
                    check("ser_word",   64'(ser_byte),       64'(wd.b));
                    check("ser_id",     64'(o_ser_id),       64'(wd.id));
                    check("ser_timing", 64'(cyc - last_dv),  64'(wd.j));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n = 1'b0;
        i_enable  = 1'b1;
        i_req     = '0;
        i_data    = '0;
        #3;
        check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        i_reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(o_busy), 64'd0);

        // Single request from requester 2
        set_slice(2, 32'hDEADBEEF);
        push_grant(2'd2, 32'hDEADBEEF, 0);
        i_req = 4'b0100;
        wait_ack(2);
        i_req = '0;
        check("single_busy_t1", 64'(o_busy), 64'd1);
        for (int j = 0; j < NW; j++) begin
            @(negedge clk);
            check("single_busy", 64'(o_busy), 64'd1);
        end
        @(negedge clk);
        check("single_idle", 64'(o_busy), 64'd0);

        // Asynchronous reset between edges clears held word and id at once
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 i_reset_n = 1'b0;
        #1 check_zero_outputs("midreset");
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fairness with all four requesting
        for (int k = 0; k < NR; k++) set_slice(k, 32'hA0A0A0A0 + k);
        push_grant(2'd0, 32'hA0A0A0A0, 0);
        push_grant(2'd1, 32'hA0A0A0A1, 6);
        push_grant(2'd2, 32'hA0A0A0A2, 6);
        push_grant(2'd3, 32'hA0A0A0A3, 6);
        push_grant(2'd0, 32'hA0A0A0A0, 6);
        i_req = 4'b1111;
        wait_ack(0);
        wait_ack(1);
        wait_ack(2);
        wait_ack(3);
        wait_ack(0);
        i_req = '0;
        repeat (8) @(negedge clk);

        // Pointer: grant 1 first (ptr -> 2), then 1010 gives 3 then 1
        push_grant(2'd1, 32'hA0A0A0A1, 0);
        push_grant(2'd3, 32'hA0A0A0A3, 6);
        push_grant(2'd1, 32'hA0A0A0A1, 6);
        i_req = 4'b0010;
        wait_ack(1);
        i_req = 4'b1010;
        wait_ack(3);
        wait_ack(1);
        i_req = '0;
        repeat (8) @(negedge clk);

        // Enable low blocks grants
        i_enable = 1'b0;
        set_slice(0, 32'h0BADF00D);
        set_slice(2, 32'hC0FFEE02);
        i_req = 4'b0101;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("disabled_ack", 64'(o_ack), 64'd0);
        end
        check("disabled_busy", 64'(o_busy), 64'd0);
        // ptr is 2 here, so requester 2 must win over 0
        push_grant(2'd2, 32'hC0FFEE02, 0);
        i_enable = 1'b1;
        wait_ack(2);
        i_req = 4'b0001;
        repeat (2) @(negedge clk);
        i_enable = 1'b0;
        check("burst_continues", 64'(o_busy), 64'd1);
        repeat (12) @(negedge clk);
        check("no_grant_after_disable", 64'(o_busy), 64'd0);

        // Reset during BUSY aborts the burst and clears ptr
        push_grant(2'd0, 32'h0BADF00D, 0);
        i_enable = 1'b1;
        wait_ack(0);
        i_req = '0;
        repeat (2) @(negedge clk);
        #2 i_reset_n = 1'b0;
        bq.delete();
        #1 check_zero_outputs("abort");
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
        @(negedge clk);
        set_slice(3, 32'h33333333);
        push_grant(2'd0, 32'h0BADF00D, 0);
        i_req = 4'b1001;
        wait_ack(0);
        i_req = '0;
        repeat (8) @(negedge clk);

        // End-to-end little-endian words
        set_slice(0, 32'h44332211);
        push_grant(2'd0, 32'h44332211, 0);
        i_req = 4'b0001;
        wait_ack(0);
        i_req = '0;
        repeat (10) @(negedge clk);

        check("grant_queue_empty", 64'(gq.size()), 64'd0);
        check("word_queue_empty",  64'(bq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
